// File: rtl/wb_pkg.sv
// Shared types, bus widths and the address decode helper for the Wishbone
// data RAM responder.
package wb_pkg;

    localparam int WB_AW   = 32;
    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    // Responder states: idle, counting wait states, normal or error termination.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        ERR  = 2'd3
    } wb_slv_state_e;

    // True when adr is word aligned and lies inside [base, base + depth*4).
    // The sum is carried in 33 bits so a window ending exactly at 2^32 still
    // compares correctly.
    function automatic logic wb_addr_hit(
        input logic [WB_AW-1:0] adr,
        input logic [WB_AW-1:0] base,
        input logic [WB_AW-1:0] depth
    );
        logic [WB_AW:0] lim;
        logic           aligned;
        logic           above;
        logic           below;
        lim     = {1'b0, base} + ({1'b0, depth} << 2);
        aligned = (adr[1:0] == 2'b00);
        above   = ({1'b0, adr} >= {1'b0, base});
        below   = ({1'b0, adr} < lim);
        return aligned & above & below;
    endfunction

endpackage

// File: rtl/byte_we_ram.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// The read register is cleared on every cycle without a read, so its output
// can drive a bus data line that must sit at zero outside a read beat.
module byte_we_ram
    import wb_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic               i_re,
    input  logic [AW-1:0]      i_addr,
    input  logic [WB_SELW-1:0] i_sel,
    input  logic [WB_DW-1:0]   i_wdata,
    output logic [WB_DW-1:0]   o_rdata
);

    logic [WB_SELW-1:0][7:0] r_mem [DEPTH_WORDS];
    logic [WB_DW-1:0]        r_rdata;

    // Byte-lane writes: only lanes whose select bit is set are updated.
    always_ff @(posedge clk) begin
        for (int b = 0; b < WB_SELW; b++) begin
            if (i_we && i_sel[b]) begin
                r_mem[i_addr][b] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Registered read; the output falls back to zero whenever no read is issued.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end else begin
            r_rdata <= {WB_DW{1'b0}};
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_data_ram_slave.sv
// Wishbone B3 classic single-beat responder backed by a byte-writable RAM.
// A request is latched in IDLE, optionally delayed by WAIT_STATES cycles and
// terminated with a one-cycle ack (hit) or err (misaligned / out of window).
// The RAM is touched only on the edge that enters ACK.
module wb_data_ram_slave
    import wb_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
    localparam logic        ZERO_WS = (WAIT_STATES == 0) ? 1'b1 : 1'b0;
    localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES - 1);

    // Parameter sanity checks, evaluated at elaboration.
    if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_chk_depth
        $error("DEPTH_WORDS must be a power of two and at least 2");
    end
    if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_chk_ws
        $error("WAIT_STATES must be in 0..15");
    end
    if ((64'(BASE_ADDR) + (64'(DEPTH_WORDS) * 64'd4)) > 64'h0000_0001_0000_0000) begin : g_chk_ovf
        $error("BASE_ADDR + DEPTH_WORDS*4 overflows the 32-bit address space");
    end
    if ((BASE_ADDR & ((DEPTH_L << 2) - 32'd1)) != 32'd0) begin : g_chk_align
        $error("BASE_ADDR must be aligned to the window size");
    end

    wb_slv_state_e     r_state;
    logic [3:0]        r_cnt;
    logic [AW-1:0]     r_idx;
    logic              r_we;
    logic [3:0]        r_sel;
    logic [31:0]       r_dat;
    logic              r_ack;
    logic              r_err;

    logic              w_req;
    logic              w_hit;
    logic              w_enter_ack;
    logic [AW-1:0]     w_ram_idx;
    logic              w_acc_we;
    logic [3:0]        w_acc_sel;
    logic [31:0]       w_acc_dat;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [31:0]       w_ram_rdata;

    // Request decode and RAM access selection. With zero wait states the
    // access happens on the same edge that samples the request, so the live
    // bus inputs are used in IDLE and the latched copies everywhere else.
    // Because the window is aligned to its own size, the word index is just
    // the low address bits above the byte offset.
    always_comb begin
        w_req       = wb_cyc_i & wb_stb_i;
        w_hit       = wb_addr_hit(wb_adr_i, BASE_ADDR, DEPTH_L);
        w_enter_ack = 1'b0;
        w_ram_idx   = r_idx;
        w_acc_we    = r_we;
        w_acc_sel   = r_sel;
        w_acc_dat   = r_dat;
        if (r_state == IDLE) begin
            w_ram_idx = wb_adr_i[AW+1:2];
            w_acc_we  = wb_we_i;
            w_acc_sel = wb_sel_i;
            w_acc_dat = wb_dat_i;
        end else begin
            w_ram_idx = r_idx;
            w_acc_we  = r_we;
            w_acc_sel = r_sel;
            w_acc_dat = r_dat;
        end
        case (r_state)
            IDLE:    w_enter_ack = w_req & w_hit & ZERO_WS;
            WAIT:    w_enter_ack = w_req & (r_cnt == 4'd0);
            default: w_enter_ack = 1'b0;
        endcase
        // Reset wins over an access on the same edge: nothing is written and
        // the read register clears.
        w_ram_we = rst & w_enter_ack & w_acc_we;
        w_ram_re = rst & w_enter_ack & ~w_acc_we;
    end

    // Responder FSM with registered ack/err and the latched request fields.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= {AW{1'b0}};
            r_we    <= 1'b0;
            r_sel   <= 4'd0;
            r_dat   <= 32'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_idx <= wb_adr_i[AW+1:2];
                        r_we  <= wb_we_i;
                        r_sel <= wb_sel_i;
                        r_dat <= wb_dat_i;
                        if (!w_hit) begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end else if (w_enter_ack) begin
                            r_state <= ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= WS_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!w_req) begin
                        // Initiator withdrew the request: abandon without access.
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                    end else if (w_enter_ack) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ACK:     r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    byte_we_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_idx),
        .i_sel   (w_acc_sel),
        .i_wdata (w_acc_dat),
        .o_rdata (w_ram_rdata)
    );

    assign wb_dat_o = w_ram_rdata;
    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;

endmodule

// File: tb/tb_wb_data_ram_slave.sv
// Scoreboard bench for wb_data_ram_slave: three responders with different
// wait-state counts, windows and depths. The driver pushes the expected
// termination (kind, data, cycle) when a request is sampled; per-instance
// monitors pop and compare whenever ack or err is seen.
module tb_wb_data_ram_slave;

    localparam int          NI         = 3;
    localparam int          WS_T   [NI] = '{1, 3, 0};
    localparam logic [31:0] BASE_T [NI] = '{32'h0000_0000, 32'h0000_2000, 32'h0000_0000};
    localparam int          DEPTH_T[NI] = '{64, 64, 16};
    localparam int          TMO        = 60;

    typedef struct packed {
        logic        is_err;
        logic        is_rd;
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc   [NI];
    logic        stb   [NI];
    logic        we    [NI];
    logic [31:0] adr   [NI];
    logic [3:0]  sel   [NI];
    logic [31:0] dat_i [NI];
    logic [31:0] dat_o [NI];
    logic        ack   [NI];
    logic        err   [NI];

    exp_t        sb_q  [NI][$];
    logic [31:0] mdl   [NI][64];
    bit          after_term[NI];
    bit          mon_en = 1'b0;
    int unsigned cyc_n  = 0;
    int          n_chk  = 0;
    int          n_err  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic bit in_window(input int g, input logic [31:0] a);
        longint off;
        off = longint'({32'd0, a}) - longint'({32'd0, BASE_T[g]});
        return (a[1:0] == 2'b00) && (off >= 0) && (off < longint'(DEPTH_T[g]) * 4);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        wb_data_ram_slave #(
            .DEPTH_WORDS (DEPTH_T[g]),
            .BASE_ADDR   (BASE_T[g]),
            .WAIT_STATES (WS_T[g])
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .wb_cyc_i (cyc[g]),
            .wb_stb_i (stb[g]),
            .wb_we_i  (we[g]),
            .wb_adr_i (adr[g]),
            .wb_sel_i (sel[g]),
            .wb_dat_i (dat_i[g]),
            .wb_dat_o (dat_o[g]),
            .wb_ack_o (ack[g]),
            .wb_err_o (err[g])
        );

        // Monitor: compare every termination against the scoreboard head.
        always @(negedge clk) begin
            exp_t e;
            if (mon_en) begin
                check($sformatf("u%0d.ack_err_excl", g), 32'(ack[g] & err[g]), 32'd0);
                if (ack[g] || err[g]) begin
                    check($sformatf("u%0d.term_expected", g), 32'(sb_q[g].size() > 0), 32'd1);
                    if (sb_q[g].size() > 0) begin
                        e = sb_q[g].pop_front();
                        check($sformatf("u%0d.kind", g), {30'd0, ack[g], err[g]},
                              e.is_err ? 32'd1 : 32'd2);
                        check($sformatf("u%0d.cycle", g), cyc_n, e.due);
                        if (e.is_rd || e.is_err) begin
                            check($sformatf("u%0d.dat", g), dat_o[g], e.data);
                        end
                    end
                end else begin
                    check($sformatf("u%0d.idle_dat", g), dat_o[g], 32'd0);
                end
            end
        end
    end

    // One transaction; called at a falling edge. keep=1 leaves the strobe up
    // so the next call forms a back-to-back request.
    task automatic txn(input int g, input bit w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d, input bit keep);
        exp_t        e;
        int unsigned edge_i;
        int          k;
        int          idx;
        cyc[g] = 1'b1; stb[g] = 1'b1; we[g] = w; adr[g] = a; sel[g] = s; dat_i[g] = d;
        if (after_term[g]) @(posedge clk);   // edge closing ACK/ERR ignores the strobe
        after_term[g] = 1'b0;
        @(posedge clk);
        edge_i   = cyc_n;
        e.is_err = !in_window(g, a);
        e.is_rd  = !w;
        e.data   = 32'd0;
        if (!e.is_err) begin
            idx = int'((a - BASE_T[g]) >> 2);
            if (w) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) mdl[g][idx][8*b +: 8] = d[8*b +: 8];
                end
            end else begin
                e.data = mdl[g][idx];
            end
            e.due = edge_i + 32'(WS_T[g]) + 32'd1;
        end else begin
            e.due = edge_i + 32'd1;
        end
        sb_q[g].push_back(e);
        @(negedge clk);
        k = 0;
        while (!(ack[g] || err[g]) && k < TMO) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("u%0d.timeout", g), 32'(k >= TMO), 32'd0);
        if (!keep) begin
            cyc[g] = 1'b0; stb[g] = 1'b0; we[g] = 1'b0;
            @(negedge clk);
        end else begin
            after_term[g] = 1'b1;
        end
    endtask

    // Write that is withdrawn after k cycles of waiting; no termination expected.
    task automatic abort_wr(input int g, input logic [31:0] a, input logic [31:0] d, input int k);
        cyc[g] = 1'b1; stb[g] = 1'b1; we[g] = 1'b1; adr[g] = a; sel[g] = 4'hF; dat_i[g] = d;
        @(posedge clk);
        repeat (k) @(negedge clk);
        cyc[g] = 1'b0; stb[g] = 1'b0; we[g] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        bit          w;
        bit          kp;
        int          r;
        int          n;
        rst = 1'b0;
        for (int g = 0; g < NI; g++) begin
            cyc[g] = 1'b0; stb[g] = 1'b0; we[g] = 1'b0;
            adr[g] = 32'd0; sel[g] = 4'd0; dat_i[g] = 32'd0; after_term[g] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("u%0d.rst_ack", g), 32'(ack[g]), 32'd0);
            check($sformatf("u%0d.rst_err", g), 32'(err[g]), 32'd0);
            check($sformatf("u%0d.rst_dat", g), dat_o[g], 32'd0);
        end
        mon_en = 1'b1;
        rst    = 1'b1;
        @(negedge clk);

        // Preload every word through the bus.
        for (int g = 0; g < NI; g++) begin
            for (int i = 0; i < DEPTH_T[g]; i++) begin
                txn(g, 1'b1, BASE_T[g] + 32'(4 * i), 4'hF,
                    (g == 2) ? 32'(i + 1) : 32'(i) * 32'h0101_0101, 1'b0);
            end
        end

        // Instance 0 (one wait state): full write, lanes, error paths, edges.
        txn(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0);
        txn(0, 1'b0, 32'h10, 4'h0, 32'd0, 1'b0);
        txn(0, 1'b1, 32'h10, 4'b0101, 32'h1122_3344, 1'b0);
        txn(0, 1'b0, 32'h10, 4'h0, 32'd0, 1'b0);
        check("u0.lane_model", mdl[0][4], 32'hDE22_BE44);
        txn(0, 1'b0, 32'h12, 4'hF, 32'd0, 1'b0);
        txn(0, 1'b0, 32'h100, 4'hF, 32'd0, 1'b0);
        txn(0, 1'b1, 32'h12, 4'hF, 32'hFFFF_FFFF, 1'b0);
        txn(0, 1'b1, 32'h100, 4'hF, 32'hFFFF_FFFF, 1'b0);
        txn(0, 1'b0, 32'h10, 4'h0, 32'd0, 1'b0);
        txn(0, 1'b0, 32'hFC, 4'h0, 32'd0, 1'b0);
        txn(0, 1'b0, 32'h0, 4'h0, 32'd0, 1'b0);

        // Instance 1 (three wait states, window at 0x2000): abort and reset.
        txn(1, 1'b1, 32'h2020, 4'hF, 32'h0000_0000, 1'b0);
        abort_wr(1, 32'h2020, 32'hCAFE_F00D, 2);
        txn(1, 1'b0, 32'h2020, 4'h0, 32'd0, 1'b0);
        txn(1, 1'b0, 32'h1FFC, 4'h0, 32'd0, 1'b0);
        txn(1, 1'b0, 32'h2100, 4'h0, 32'd0, 1'b0);
        txn(1, 1'b0, 32'h20FC, 4'h0, 32'd0, 1'b0);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h2030;
        sel[1] = 4'hF; dat_i[1] = 32'h5555_AAAA;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("u1.midrst_ack", 32'(ack[1]), 32'd0);
        check("u1.midrst_err", 32'(err[1]), 32'd0);
        check("u1.midrst_dat", dat_o[1], 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        txn(1, 1'b0, 32'h2030, 4'h0, 32'd0, 1'b0);

        // Instance 2 (no wait states): back-to-back reads and a sel=0 write.
        txn(2, 1'b0, 32'h0, 4'h0, 32'd0, 1'b1);
        txn(2, 1'b0, 32'h4, 4'h0, 32'd0, 1'b1);
        txn(2, 1'b0, 32'h8, 4'h0, 32'd0, 1'b0);
        txn(2, 1'b1, 32'hC, 4'h0, 32'h7777_7777, 1'b0);
        txn(2, 1'b0, 32'hC, 4'h0, 32'd0, 1'b0);

        // Randomised traffic on every instance.
        for (int g = 0; g < NI; g++) begin
            n = 150;
            for (int i = 0; i < n; i++) begin
                r = int'($urandom_range(0, 9));
                if (r == 0) begin
                    a = BASE_T[g] + 32'($urandom_range(0, DEPTH_T[g] - 1)) * 32'd4
                        + 32'($urandom_range(1, 3));
                end else if (r == 1) begin
                    a = BASE_T[g] + 32'(DEPTH_T[g] * 4) + 32'($urandom_range(0, 7)) * 32'd4;
                end else if (r == 2) begin
                    a = BASE_T[g] - 32'($urandom_range(1, 4)) * 32'd4;
                end else begin
                    a = BASE_T[g] + 32'($urandom_range(0, DEPTH_T[g] - 1)) * 32'd4;
                end
                w  = bit'($urandom_range(0, 1));
                kp = (i == n - 1) ? 1'b0 : bit'($urandom_range(0, 1));
                txn(g, w, a, 4'($urandom_range(0, 15)), $urandom, kp);
            end
        end

        repeat (10) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("u%0d.sb_empty", g), 32'(sb_q[g].size()), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
